// File: rtl/register_file.sv
// 32x32 register file: one write port, two independently enabled registered read ports.
// Define REGFILE_BYPASS_EN to forward same-edge write data to a colliding read port.
module register_file (
  output logic [31:0] OutA,
  output logic [31:0] OutB,
  input  logic [31:0] IN,
  input  logic        clk,
  input  logic        WE,
  input  logic [4:0]  WA,
  input  logic        RE_A,
  input  logic        RE_B,
  input  logic [4:0]  RA_A,
  input  logic [4:0]  RA_B,
  input  logic        rst
);

  localparam int unsigned DEPTH = 32;
  localparam int unsigned WIDTH = 32;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] out_a_q, out_a_d;
  logic [WIDTH-1:0] out_b_q, out_b_d;

  // Next-state for the array and both read registers; disabled ports hold.
  always_comb begin
    mem_d   = mem_q;
    out_a_d = out_a_q;
    out_b_d = out_b_q;

    if (WE) begin
      mem_d[WA] = IN;
    end

`ifdef REGFILE_BYPASS_EN
    if (RE_A) begin
      out_a_d = (WE && (RA_A == WA)) ? IN : mem_q[RA_A];
    end
    if (RE_B) begin
      out_b_d = (WE && (RA_B == WA)) ? IN : mem_q[RA_B];
    end
`else
    // Reads see pre-edge contents; a colliding write shows up on the next read.
    if (RE_A) begin
      out_a_d = mem_q[RA_A];
    end
    if (RE_B) begin
      out_b_d = mem_q[RA_B];
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      out_a_q <= '0;
      out_b_q <= '0;
    end else begin
      mem_q   <= mem_d;
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
    end
  end

  assign OutA = out_a_q;
  assign OutB = out_b_q;

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file; expectations follow REGFILE_BYPASS_EN.
module tb_register_file;

  logic [31:0] OutA, OutB, IN;
  logic        clk, WE, RE_A, RE_B, rst;
  logic [4:0]  WA, RA_A, RA_B;

  int n_checks = 0;
  int n_fail   = 0;

  register_file dut (
    .OutA(OutA), .OutB(OutB), .IN(IN), .clk(clk), .WE(WE), .WA(WA),
    .RE_A(RE_A), .RE_B(RE_B), .RA_A(RA_A), .RA_B(RA_B), .rst(rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle so outputs can be sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    WE = 1'b0; RE_A = 1'b0; RE_B = 1'b0;
    WA = '0; RA_A = '0; RA_B = '0; IN = '0;
  endtask

  function automatic logic [31:0] fill_val(input int a);
    return (a == 0) ? 32'd320 : 32'(a * 10);
  endfunction

  initial begin
    int wide_addr;
    logic [31:0] hold_b;
    logic [31:0] exp_col_a, exp_col_b;

`ifdef REGFILE_BYPASS_EN
    exp_col_a = 32'd99;
    exp_col_b = 32'd123;
`else
    exp_col_a = 32'd70;
    exp_col_b = 32'd90;
`endif

    idle();
    rst = 1'b1;
    #2;
    check("reset_outa", OutA, 32'd0);
    check("reset_outb", OutB, 32'd0);
    step();
    rst = 1'b0;

    // Fill i*10 into 1..31, then 320 via address 32 which truncates to 0.
    for (int i = 1; i < 32; i++) begin
      WE = 1'b1; WA = 5'(i); IN = 32'(i * 10);
      step();
    end
    wide_addr = 32;
    WA = wide_addr[4:0]; IN = 32'd320;
    step();
    WE = 1'b0;

    RE_A = 1'b1; RE_B = 1'b1;
    RA_A = 5'd5; RA_B = 5'd5; step();
    check("fill_a5", OutA, 32'd50);
    check("fill_b5", OutB, 32'd50);
    RA_A = 5'd31; RA_B = 5'd0; step();
    check("fill_a31", OutA, 32'd310);
    check("fill_b0", OutB, 32'd320);
    RA_A = 5'd0; RA_B = 5'd31; step();
    check("fill_a0", OutA, 32'd320);
    check("fill_b31", OutB, 32'd310);

    hold_b = 32'd310;
    RE_A = 1'b1; RA_A = 5'd3; RE_B = 1'b0; RA_B = 5'd4; step();
    check("indep_a_read", OutA, 32'd30);
    check("indep_b_hold", OutB, hold_b);
    RE_A = 1'b0; RA_A = 5'd9; RE_B = 1'b1; RA_B = 5'd4; step();
    check("indep_a_hold", OutA, 32'd30);
    check("indep_b_read", OutB, 32'd40);

    // Write enable low: array must keep its values.
    RE_A = 1'b0; RE_B = 1'b0; WE = 1'b0;
    for (int i = 0; i < 32; i++) begin
      WA = 5'(i); IN = 32'(i * 10 + 1);
      step();
    end
    RE_A = 1'b1; RE_B = 1'b1;
    for (int i = 0; i < 32; i++) begin
      RA_A = 5'(i); RA_B = 5'((i + 16) % 32);
      step();
      check("nowe_a", OutA, fill_val(i));
      check("nowe_b", OutB, fill_val((i + 16) % 32));
    end

    // Collision on port A while port B reads a different address.
    idle();
    WE = 1'b1; WA = 5'd7; IN = 32'd70; step();
    WA = 5'd7; IN = 32'd99;
    RE_A = 1'b1; RA_A = 5'd7; RE_B = 1'b1; RA_B = 5'd8; step();
    check("col_a", OutA, exp_col_a);
    check("col_other_b", OutB, 32'd80);
    WE = 1'b0; RA_A = 5'd7; RA_B = 5'd7; step();
    check("col_after_a", OutA, 32'd99);
    check("col_after_b", OutB, 32'd99);

    // Collision on port B only.
    WE = 1'b1; WA = 5'd9; IN = 32'd123;
    RA_A = 5'd7; RA_B = 5'd9; step();
    check("colb_a", OutA, 32'd99);
    check("colb_b", OutB, exp_col_b);
    WE = 1'b0; RA_A = 5'd9; RA_B = 5'd9; step();
    check("colb_after_a", OutA, 32'd123);
    check("colb_after_b", OutB, 32'd123);

    // Async reset between edges while writes are in flight.
    WE = 1'b1; WA = 5'd2; IN = 32'd555;
    RA_A = 5'd5; RA_B = 5'd6; step();
    check("pre_rst_a", OutA, 32'd50);
    check("pre_rst_b", OutB, 32'd60);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_a", OutA, 32'd0);
    check("async_rst_b", OutB, 32'd0);
    step();
    #2;
    rst = 1'b0;
    idle();
    step();
    check("post_rst_hold_a", OutA, 32'd0);
    check("post_rst_hold_b", OutB, 32'd0);

    RE_A = 1'b1; RE_B = 1'b1;
    for (int i = 0; i < 32; i++) begin
      RA_A = 5'(i); RA_B = 5'(31 - i);
      step();
      check("rst_zero_a", OutA, 32'd0);
      check("rst_zero_b", OutB, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

32-entry × 32-bit general-purpose register file with one write port and two independently enabled read ports (A and B). It sits in the datapath between writeback and operand fetch. All storage and both read outputs are clocked on `clk` and cleared by an asynchronous reset. Register 0 is an ordinary storage location, not hard-wired to zero.

## Interface
- No parameters; depth fixed at 32, width fixed at 32.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  reset, asynchronous, active-high; clears all registers and both outputs.
- `IN`  input  32  write data.
- `WE`  input  1  write enable, active-high.
- `WA`  input  5  write address.
- `RE_A`  input  1  port A read enable, active-high.
- `RA_A`  input  5  port A read address.
- `RE_B`  input  1  port B read enable, active-high.
- `RA_B`  input  5  port B read address.
- `OutA`  output  32  port A read data, registered.
- `OutB`  output  32  port B read data, registered.
- Positional port order: `OutA, OutB, IN, clk, WE, WA, RE_A, RE_B, RA_A, RA_B, rst`.

## Operation
- Write: on a rising `clk` edge with `WE`=1, `mem[WA]` <= `IN`. With `WE`=0 the array is unchanged.
- Addresses are 5 bits. Wider values driven by a bench truncate modulo 32, so address 32 maps to 0.
- Read port A: on a rising edge with `RE_A`=1, `OutA` <= `mem[RA_A]`. With `RE_A`=0, `OutA` holds its previous value.
- Read port B: same behaviour, using `RE_B` and `RA_B` to drive `OutB`.
- Ports A and B are fully independent. Both may read the same address in the same cycle.
- Same-edge write/read collision (`WE`=1, `RE_x`=1, `RA_x`==`WA`): governed by the bypass option in Configuration.
- No address is special. Register 0 is readable and writable like any other.
- Reset: all 32 entries = 0, `OutA` = 0, `OutB` = 0.

## Timing
- Write latency: data is in the array after the edge where `WE`=1.
- Read latency: 1 cycle. The address and enable sampled at edge N appear on `OutA`/`OutB` after edge N.
- A value written at edge N and read with a read issued at edge N+1 returns the new data.
- Reset asserts immediately, independent of `clk`, and overrides `WE`/`RE`.
- The first write or read is accepted on the first rising edge after `rst` deasserts.
- Reset mid-operation discards any in-flight write. The outputs read 0 until the next enabled read.

## Configuration
- `REGFILE_BYPASS_EN` defined (write-through forwarding):
  - A same-edge collision returns `IN` on the colliding output.
  - This is evaluated per port.
- `REGFILE_BYPASS_EN` undefined:
  - A same-edge collision returns the old contents of `mem[RA_x]`.
  - The new value is visible from the next enabled read onward.

## Test plan
- Reset: assert `rst` with the array preloaded, then read addresses 0–31 on both ports -> every `OutA`/`OutB` = 0.
- Fill and readback:
  - Write `IN`=i*10 to `WA`=i for i=1..31, then `IN`=320 to `WA`=0 (truncated 32).
  - Read with `RE_A`=`RE_B`=1 -> `mem[5]` reads 50, `mem[31]` reads 310, `mem[0]` reads 320.
- Independent enables:
  - Read `RA_A`=3 with `RE_A`=1 and `RA_B`=4 with `RE_B`=0 -> `OutA`=30 and `OutB` holds its prior value.
  - Swap the enables -> `OutA` holds, `OutB`=40.
- Write disabled: `WE`=0 while cycling `WA`/`IN` through i / i*10+1 -> readback still returns the original i*10 values.
- Collision:
  - Setup: `mem[7]`=70, then `WE`=1, `WA`=7, `IN`=99 with `RE_A`=1, `RA_A`=7 on the same edge.
  - With `REGFILE_BYPASS_EN` -> `OutA`=99. Without it -> `OutA`=70.
  - In both builds, the following read of address 7 returns 99.
- Async reset mid-stream: pulse `rst` between clock edges during writes -> outputs go to 0 immediately, before the next edge, and the array reads all-zero afterwards.
